shape_cmd_arbiter: RTL and testbench

SHAPE_CMD_ARBITER -- requirements
Module: shape_cmd_arbiter

---
 rtl/shape_cmd_arbiter.sv | 152 +++++++++++++++
 tb/tb_shape_cmd_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/shape_cmd_arbiter.sv
// Two-requester round-robin arbiter that turns SHAPE/OPERATION commands into
// a write-then-readback sequence on a processor control register.
module shape_cmd_arbiter #(
    parameter int                 SHAPE_LSB      = 0,
    parameter int                 OP_LSB         = 16,
    parameter int                 FIELD_W        = 3,
    parameter logic [FIELD_W-1:0] KEEP_SHAPE     = {FIELD_W{1'b1}},
    parameter logic [FIELD_W-1:0] KEEP_OPERATION = {FIELD_W{1'b1}}
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0][FIELD_W-1:0] req_shape,
    input  logic [1:0][FIELD_W-1:0] req_operation,
    output logic [1:0]              rsp_valid,
    output logic                    rsp_ok,
    output logic                    write,
    output logic [31:0]             write_data,
    output logic                    read,
    input  logic [31:0]             read_data,
    input  logic                    error,
    output logic [15:0]             reject_count
);

    typedef enum logic [2:0] {
        INIT_RD,
        INIT_WAIT,
        IDLE,
        WR,
        RD,
        RD_WAIT,
        RSP
    } state_t;

    state_t             state_q;
    logic               last_q;
    logic               id_q;
    logic [FIELD_W-1:0] cmd_shape_q;
    logic [FIELD_W-1:0] cmd_op_q;
    logic [FIELD_W-1:0] shadow_shape_q;
    logic [FIELD_W-1:0] shadow_op_q;
    logic               err_flag_q;
    logic               ok_q;
    logic [15:0]        reject_count_q;

    logic               gnt_d;
    logic               handshake_d;
    logic [FIELD_W-1:0] rd_shape_d;
    logic [FIELD_W-1:0] rd_op_d;
    logic [FIELD_W-1:0] exp_shape_d;
    logic [FIELD_W-1:0] exp_op_d;
    logic               ok_d;
    logic               unused_rd_bits;

    function automatic logic [31:0] build_word(input logic [FIELD_W-1:0] op,
                                               input logic [FIELD_W-1:0] shp);
        logic [31:0] w;
        w = '0;
        w[OP_LSB +: FIELD_W]    = op;
        w[SHAPE_LSB +: FIELD_W] = shp;
        return w;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // Requester 1 is preferred only when it was not the last one served.
    always_comb begin
        gnt_d = ~last_q;
        unique case (req_valid)
            2'b01:   gnt_d = 1'b0;
            2'b10:   gnt_d = 1'b1;
            default: gnt_d = ~last_q;
        endcase
    end

    assign req_ready   = (state_q == IDLE) ? (req_valid & (gnt_d ? 2'b10 : 2'b01)) : 2'b00;
    assign handshake_d = |req_ready;

    assign rd_shape_d  = read_data[SHAPE_LSB +: FIELD_W];
    assign rd_op_d     = read_data[OP_LSB +: FIELD_W];
    assign exp_shape_d = (cmd_shape_q == KEEP_SHAPE) ? shadow_shape_q : cmd_shape_q;
    assign exp_op_d    = (cmd_op_q == KEEP_OPERATION) ? shadow_op_q : cmd_op_q;
    assign ok_d        = !err_flag_q && (rd_shape_d == exp_shape_d) && (rd_op_d == exp_op_d);

    // Bits outside the two fields carry no meaning for this block.
    assign unused_rd_bits = ^read_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= INIT_RD;
            last_q         <= 1'b1;
            id_q           <= 1'b0;
            shadow_shape_q <= '0;
            shadow_op_q    <= '0;
            reject_count_q <= '0;
        end else begin
            unique case (state_q)
                INIT_RD: begin
                    state_q <= INIT_WAIT;
                end
                INIT_WAIT: begin
                    shadow_shape_q <= rd_shape_d;
                    shadow_op_q    <= rd_op_d;
                    state_q        <= IDLE;
                end
                IDLE: begin
                    if (handshake_d) begin
                        id_q        <= gnt_d;
                        last_q      <= gnt_d;
                        cmd_shape_q <= req_shape[gnt_d];
                        cmd_op_q    <= req_operation[gnt_d];
                        state_q     <= WR;
                    end
                end
                WR: begin
                    state_q <= RD;
                end
                RD: begin
                    err_flag_q <= error;
                    state_q    <= RD_WAIT;
                end
                RD_WAIT: begin
                    ok_q           <= ok_d;
                    shadow_shape_q <= rd_shape_d;
                    shadow_op_q    <= rd_op_d;
                    state_q        <= RSP;
                end
                RSP: begin
                    if (!ok_q) begin
                        reject_count_q <= sat_inc(reject_count_q);
                    end
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= INIT_RD;
                end
            endcase
        end
    end

    // Reset parks the FSM in INIT_RD; the read strobe must stay low until rst drops.
    assign read         = ((state_q == INIT_RD) && !rst) || (state_q == RD);
    assign write        = (state_q == WR);
    assign write_data   = (state_q == WR) ? build_word(cmd_op_q, cmd_shape_q) : 32'd0;
    assign rsp_valid    = (state_q == RSP) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_ok       = (state_q == RSP) && ok_q;
    assign reject_count = reject_count_q;

endmodule

// File: tb/tb_shape_cmd_arbiter.sv
// Directed bench for shape_cmd_arbiter: reset/init readback, command sequences,
// KEEP handling, errors, round-robin, mid-sequence reset and counter saturation.
module tb_shape_cmd_arbiter;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0][2:0] req_shape;
    logic [1:0][2:0] req_operation;
    logic [1:0]      rsp_valid;
    logic            rsp_ok;
    logic            write;
    logic [31:0]     write_data;
    logic            read;
    logic [31:0]     read_data;
    logic            error;
    logic [15:0]     reject_count;

    int n_chk = 0;
    int n_bad = 0;

    localparam logic [2:0] K = 3'b111;

    always #5 clk = ~clk;

    shape_cmd_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_shape    (req_shape),
        .req_operation(req_operation),
        .rsp_valid    (rsp_valid),
        .rsp_ok       (rsp_ok),
        .write        (write),
        .write_data   (write_data),
        .read         (read),
        .read_data    (read_data),
        .error        (error),
        .reject_count (reject_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Starts at a negedge with the DUT in IDLE, ends at the negedge of T+5 (IDLE again).
    task automatic do_cmd(input int id, input logic [2:0] shp, input logic [2:0] op,
                          input logic [31:0] rdata, input logic err,
                          input logic [31:0] exp_wd, input logic exp_ok,
                          input logic [15:0] exp_rej);
        logic [1:0] one;
        one = (id == 1) ? 2'b10 : 2'b01;
        req_shape[id]     = shp;
        req_operation[id] = op;
        req_valid         = one;
        #1;
        chk("hs_ready", {30'd0, req_ready}, {30'd0, one});
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        chk("wr_strobes", {30'd0, write, read}, 32'd2);
        chk("wr_data", write_data, exp_wd);
        chk("wr_ready", {30'd0, req_ready}, 32'd0);
        @(negedge clk);
        error     = err;
        read_data = rdata;
        #1;
        chk("rd_strobes", {30'd0, write, read}, 32'd1);
        @(negedge clk);
        error = 1'b0;
        #1;
        chk("rdwait_quiet", {28'd0, write, read, rsp_valid}, 32'd0);
        @(negedge clk);
        #1;
        chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, one});
        chk("rsp_ok", {31'd0, rsp_ok}, {31'd0, exp_ok});
        @(negedge clk);
        #1;
        chk("rsp_done", {29'd0, rsp_valid, rsp_ok}, 32'd0);
        chk("reject_count", {16'd0, reject_count}, {16'd0, exp_rej});
    endtask

    initial begin
        rst           = 1'b1;
        req_valid     = 2'b00;
        req_shape     = '0;
        req_operation = '0;
        read_data     = 32'h0002_0001;
        error         = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_outputs", {26'd0, req_ready, rsp_valid, rsp_ok, write, read}, 32'd0);
        chk("rst_wdata", write_data, 32'd0);
        chk("rst_reject", {16'd0, reject_count}, 32'd0);

        // Release; a requester waiting from the first cycle must not be served early.
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 2'b01;
        #1;
        chk("init_read", {31'd0, read}, 32'd1);
        chk("init_ready1", {30'd0, req_ready}, 32'd0);
        @(negedge clk);
        #1;
        chk("init_wait", {30'd0, req_ready}, 32'd0);
        chk("init_wait_rd", {31'd0, read}, 32'd0);
        @(negedge clk);

        // Shadows loaded as shape=1 op=2 at init
        do_cmd(0, K, K, 32'h0002_0001, 1'b0, 32'h0007_0007, 1'b1, 16'd0);
        do_cmd(0, 3'd3, 3'd1, 32'h0001_0003, 1'b0, 32'h0001_0003, 1'b1, 16'd0);
        do_cmd(1, 3'd2, 3'd4, 32'h0004_0002, 1'b0, 32'h0004_0002, 1'b1, 16'd0);
        do_cmd(1, K, 3'd4, 32'h0004_0002, 1'b0, 32'h0004_0007, 1'b1, 16'd0);
        do_cmd(1, K, 3'd4, 32'h0004_0005, 1'b0, 32'h0004_0007, 1'b0, 16'd1);
        do_cmd(0, 3'd5, 3'd4, 32'h0004_0005, 1'b1, 32'h0004_0005, 1'b0, 16'd2);
        do_cmd(0, 3'd6, 3'd0, 32'h8008_0006, 1'b0, 32'h0000_0006, 1'b1, 16'd2);
        do_cmd(1, 3'd1, K, 32'h0000_0001, 1'b0, 32'h0007_0001, 1'b1, 16'd2);

        // Both requesting: last served was 1, so grants go 0,1,0,1 every 5 cycles.
        req_shape     = {K, K};
        req_operation = {K, K};
        req_valid     = 2'b11;
        for (int c = 0; c < 20; c++) begin
            #1;
            chk("rr_ready", {30'd0, req_ready},
                (c % 5 == 0) ? (((c / 5) % 2 == 0) ? 32'd1 : 32'd2) : 32'd0);
            chk("rr_excl", {31'd0, write & read}, 32'd0);
            @(negedge clk);
        end
        req_valid = 2'b00;
        #1;
        chk("rr_reject", {16'd0, reject_count}, 32'd2);

        // Abort a command with reset during its RD cycle.
        req_shape[1]     = 3'd3;
        req_operation[1] = 3'd3;
        req_valid        = 2'b10;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_outputs", {26'd0, req_ready, rsp_valid, rsp_ok, write, read}, 32'd0);
        chk("abort_reject", {16'd0, reject_count}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("abort_norsp", {30'd0, rsp_valid}, 32'd0);
        end
        read_data = 32'h0002_0001;
        rst       = 1'b0;
        #1;
        chk("rerelease_read", {31'd0, read}, 32'd1);
        chk("rerelease_rsp", {30'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        #1;
        chk("rerelease_wait", {31'd0, read}, 32'd0);
        @(negedge clk);

        // Priority back to 0; a drop before handshake must not move the pointer.
        req_valid = 2'b11;
        #1;
        chk("prio_both", {30'd0, req_ready}, 32'd1);
        req_valid = 2'b10;
        #1;
        chk("prio_single", {30'd0, req_ready}, 32'd2);
        req_valid = 2'b11;
        #1;
        chk("prio_kept", {30'd0, req_ready}, 32'd1);
        req_valid = 2'b00;
        @(negedge clk);
        do_cmd(0, K, K, 32'h0002_0001, 1'b0, 32'h0007_0007, 1'b1, 16'd0);

        // Saturation of the reject counter.
        force dut.reject_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.reject_count_q;
        do_cmd(0, 3'd1, 3'd2, 32'h0002_0003, 1'b0, 32'h0002_0001, 1'b0, 16'hFFFF);
        do_cmd(0, 3'd1, 3'd2, 32'h0002_0003, 1'b0, 32'h0002_0001, 1'b0, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
